// File: rtl/cla_slice_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract on a shared external SLICE-bit CLA, one slice per cycle, low slice first.
// Accept in IDLE, NSLICE RUN cycles, then hold the result in DONE until out_ready.
module cla_slice_sequencer #(
    parameter int WIDTH = 51,
    parameter int SLICE = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cout,
    output logic [SLICE-1:0] slc_a,
    output logic [SLICE-1:0] slc_b,
    output logic             slc_cin,
    input  logic [SLICE-1:0] slc_s,
    input  logic             slc_cout
);

    localparam int NSLICE   = (WIDTH + SLICE - 1) / SLICE;
    localparam int PW       = NSLICE * SLICE;
    localparam int REM      = WIDTH % SLICE;
    localparam int COUT_BIT = (REM == 0) ? 0 : REM;
    localparam int IW       = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [PW-1:0]    a_pad;
    logic [PW-1:0]    b_pad;
    logic [WIDTH-1:0] sum_nxt;
    logic             last;

    // b_reg already holds the inverted operand, so padding zeros land after inversion.
    assign a_pad = PW'(a_reg);
    assign b_pad = PW'(b_reg);
    assign last  = (idx == LAST_IDX);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        slc_a   = '0;
        slc_b   = '0;
        slc_cin = 1'b0;
        if (state == RUN) begin
            slc_a   = a_pad[int'(idx)*SLICE +: SLICE];
            slc_b   = b_pad[int'(idx)*SLICE +: SLICE];
            slc_cin = carry;
        end
    end

    // Merge the current CLA slice into the result; bits beyond WIDTH are dropped.
    always_comb begin
        sum_nxt = out_s;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i / SLICE) == int'(idx)) begin
                sum_nxt[i] = slc_s[i % SLICE];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            out_s    <= '0;
            out_cout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b ^ {WIDTH{in_sub}};
                        carry <= in_sub;
                        idx   <= '0;
                        out_s <= '0;
                    end
                end
                RUN: begin
                    out_s <= sum_nxt;
                    carry <= slc_cout;
                    idx   <= idx + IW'(1);
                    // With a padded top slice the true carry out is the first padding sum bit.
                    if (last) begin
                        out_cout <= (REM == 0) ? slc_cout : slc_s[COUT_BIT];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Directed bench for cla_slice_sequencer with a behavioural CLA slice on the shared-adder port.
module tb_cla_slice_sequencer;

    localparam int W  = 51;
    localparam int S  = 17;
    localparam int W2 = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_s;
    logic          out_cout;
    logic [S-1:0]  slc_a;
    logic [S-1:0]  slc_b;
    logic          slc_cin;
    logic [S-1:0]  slc_s;
    logic          slc_cout;

    logic          w_in_valid = 1'b0;
    logic          w_in_ready;
    logic [W2-1:0] w_in_a = '0;
    logic [W2-1:0] w_in_b = '0;
    logic          w_out_valid;
    logic          w_out_ready = 1'b0;
    logic [W2-1:0] w_out_s;
    logic          w_out_cout;
    logic [S-1:0]  w_slc_a;
    logic [S-1:0]  w_slc_b;
    logic          w_slc_cin;
    logic [S-1:0]  w_slc_s;
    logic          w_slc_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {slc_cout, slc_s}     = (S+1)'(slc_a) + (S+1)'(slc_b) + (S+1)'(slc_cin);
    assign {w_slc_cout, w_slc_s} = (S+1)'(w_slc_a) + (S+1)'(w_slc_b) + (S+1)'(w_slc_cin);

    cla_slice_sequencer #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .out_s(out_s), .out_cout(out_cout),
        .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin),
        .slc_s(slc_s), .slc_cout(slc_cout)
    );

    cla_slice_sequencer #(.WIDTH(W2), .SLICE(S)) dut_w50 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_sub(1'b0), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_s(w_out_s), .out_cout(w_out_cout),
        .slc_a(w_slc_a), .slc_b(w_slc_b), .slc_cin(w_slc_cin),
        .slc_s(w_slc_s), .slc_cout(w_slc_cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operation, wait (bounded) for out_valid; lat counts edges from the accept edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output int lat);
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sub = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("out_valid_timeout", out_valid, 1'b1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 1'b0);
    endtask

    initial begin
        int lat;
        logic [W-1:0] ra, rb, hs;
        logic         rsub, hc;
        logic [W:0]   mdl;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_s", out_s, '0);
        chk("rst_out_cout", out_cout, 1'b0);
        chk("rst_slc", {slc_a, slc_b, slc_cin}, '0);

        // Full-width carry ripple and latency
        do_op(51'h7FFFFFFFFFFFF, 51'h1, 1'b0, lat);
        chk("t1_latency", 64'(lat), 64'd4);
        chk("t1_out_s", out_s, '0);
        chk("t1_out_cout", out_cout, 1'b1);
        release_result();
        chk("t1_in_ready_back", in_ready, 1'b1);

        // Subtraction both ways; also see B inverted on the slice bus
        in_a = 51'd5; in_b = 51'd3; in_sub = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t2_slc_b_inv", slc_b, 17'h1FFFC);
        chk("t2_slc_cin0", slc_cin, 1'b1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("t2a_latency", 64'(lat), 64'd4);
        chk("t2a_out_s", out_s, 51'd2);
        chk("t2a_out_cout", out_cout, 1'b1);
        release_result();
        do_op(51'd3, 51'd5, 1'b1, lat);
        chk("t2b_out_s", out_s, 51'h7FFFFFFFFFFFE);
        chk("t2b_out_cout", out_cout, 1'b0);
        release_result();

        // Carry from slice 0 into slice 1
        in_a = 51'h1FFFF; in_b = 51'h1; in_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t3_slc_a0", slc_a, 17'h1FFFF);
        chk("t3_slc_cin0", slc_cin, 1'b0);
        tick();
        chk("t3_slc_cin1", slc_cin, 1'b1);
        chk("t3_slc_a1", slc_a, 17'h0);
        tick();
        chk("t3_slc_cin2", slc_cin, 1'b0);
        tick();
        chk("t3_out_valid", out_valid, 1'b1);
        chk("t3_out_s", out_s, 51'h20000);
        chk("t3_out_cout", out_cout, 1'b0);
        release_result();

        // Backpressure with ignored input pulses
        do_op(51'h123456789ABC, 51'h1000, 1'b0, lat);
        chk("t4_out_s", out_s, 51'h12345678AABC);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_a = 51'h55555;
            in_b = 51'h77777;
            in_sub = 1'b1;
            tick();
            chk("t4_hold_valid", out_valid, 1'b1);
            chk("t4_hold_s", out_s, 51'h12345678AABC);
            chk("t4_hold_cout", out_cout, 1'b0);
            chk("t4_in_ready", in_ready, 1'b0);
            chk("t4_slc_quiet", {slc_a, slc_b, slc_cin}, '0);
        end
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        release_result();
        chk("t4_idle_after", in_ready, 1'b1);
        chk("t4_retain_s", out_s, 51'h12345678AABC);

        // Reset during the second RUN cycle
        in_a = 51'd100; in_b = 51'd200; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t5_running", in_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_in_ready", in_ready, 1'b1);
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_out_s", out_s, '0);
        chk("t5_slc", {slc_a, slc_b, slc_cin}, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_pulse", out_valid, 1'b0);
        end
        do_op(51'd7, 51'd9, 1'b0, lat);
        chk("t5_out_s_16", out_s, 51'd16);
        chk("t5_out_cout", out_cout, 1'b0);
        release_result();

        // Random back-to-back against an arithmetic model
        for (int n = 0; n < 1000; n++) begin
            ra   = W'({$urandom, $urandom});
            rb   = W'({$urandom, $urandom});
            rsub = 1'($urandom_range(0, 1));
            mdl  = {1'b0, ra} + {1'b0, (rsub ? ~rb : rb)} + (W+1)'(rsub);
            do_op(ra, rb, rsub, lat);
            hs = out_s;
            hc = out_cout;
            chk("t6_rand_s", hs, mdl[W-1:0]);
            chk("t6_rand_cout", hc, mdl[W]);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // 50-bit build: carry out taken from the padded top slice
        w_in_a = 50'h3FFFFFFFFFFFF; w_in_b = 50'h1; w_in_valid = 1'b1;
        chk("w50_in_ready", w_in_ready, 1'b1);
        tick();
        w_in_valid = 1'b0;
        lat = 1;
        while (!w_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("w50_latency", 64'(lat), 64'd4);
        chk("w50_out_s", w_out_s, '0);
        chk("w50_out_cout", w_out_cout, 1'b1);
        w_out_ready = 1'b1;
        tick();
        w_out_ready = 1'b0;
        chk("w50_out_valid_drop", w_out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
